// File: rtl/line_raster_pkg.sv
// Shared types for the clip/raster pipeline: screen point, raster FSM encoding
// and a small coordinate helper.
package line_raster_pkg;

  localparam int COORD_W = 10;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } Point2D;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_DRAW  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/line_raster_bresenham_step.sv
// One Bresenham iteration: from the current pixel and error term, produce the
// next pixel and error term. Purely combinational.
module line_raster_bresenham_step
  import line_raster_pkg::*;
#(
  parameter int ERR_W = COORD_W + 2
) (
  input  Point2D                   cur,
  input  logic signed [ERR_W-1:0]  err,
  input  logic signed [ERR_W-1:0]  dx,
  input  logic signed [ERR_W-1:0]  dy,
  input  logic                     sx_neg,
  input  logic                     sy_neg,
  output Point2D                   next_cur,
  output logic signed [ERR_W-1:0]  next_err
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  // e2 keeps one spare bit so 2*err can never wrap.
  logic signed [ERR_W:0] e2;
  logic signed [ERR_W:0] dx_w;
  logic signed [ERR_W:0] dy_w;
  logic                  step_x;
  logic                  step_y;

  always_comb begin
    e2       = {err, 1'b0};
    dx_w     = {dx[ERR_W-1], dx};
    dy_w     = {dy[ERR_W-1], dy};
    step_x   = (e2 >= dy_w);
    step_y   = (e2 <= dx_w);
    next_err = err + (step_x ? dy : '0) + (step_y ? dx : '0);
    next_cur = cur;
    if (step_x) next_cur.x = sx_neg ? (cur.x - ONE) : (cur.x + ONE);
    if (step_y) next_cur.y = sy_neg ? (cur.y - ONE) : (cur.y + ONE);
  end

endmodule

// File: rtl/line_raster.sv
// Bresenham line rasterizer: takes one clipped line per handshake from the clip
// stage and streams its pixels on a valid/ready interface.
module line_raster
  import line_raster_pkg::*;
#(
  // Point2D port width is fixed by the package; override both together.
  parameter int COORD_W = line_raster_pkg::COORD_W,
  parameter int ERR_W   = COORD_W + 2
) (
  input  logic   clk,
  input  logic   n_rst,
  input  Point2D line_p0,
  input  Point2D line_p1,
  input  logic   line_ready,
  input  logic   line_reject,
  output logic   read_line,
  output Point2D pixel,
  output logic   pixel_valid,
  input  logic   pixel_ready,
  output logic   line_done,
  output logic   busy
);

  // Pixel stream: a pixel transfers on a cycle where pixel_valid and
  // pixel_ready are both high; while pixel_ready is low the pixel and
  // pixel_valid hold unchanged.
  logic [2:0]              state;
  logic [2:0]              state_d;
  Point2D                  p0_q;
  Point2D                  p1_q;
  logic                    reject_q;
  Point2D                  cur;
  logic signed [ERR_W-1:0] err;
  logic signed [ERR_W-1:0] dx;
  logic signed [ERR_W-1:0] dy;
  logic                    sx_neg;
  logic                    sy_neg;

  Point2D                  next_cur;
  logic signed [ERR_W-1:0] next_err;
  logic [ERR_W-1:0]        abs_x;
  logic [ERR_W-1:0]        abs_y;
  logic                    accept;
  logic                    at_end;

  line_raster_bresenham_step #(
    .ERR_W (ERR_W)
  ) u_step (
    .cur      (cur),
    .err      (err),
    .dx       (dx),
    .dy       (dy),
    .sx_neg   (sx_neg),
    .sy_neg   (sy_neg),
    .next_cur (next_cur),
    .next_err (next_err)
  );

  assign abs_x = ERR_W'(abs_diff(p0_q.x, p1_q.x));
  assign abs_y = ERR_W'(abs_diff(p0_q.y, p1_q.y));

  // Outputs decode straight from the state register so reset clears them at once.
  assign read_line   = (state == ST_LOAD);
  assign pixel_valid = (state == ST_DRAW) & ~reject_q;
  assign pixel       = pixel_valid ? cur : '0;
  assign line_done   = (state == ST_DONE);
  assign busy        = (state != ST_IDLE);

  assign accept = pixel_valid & pixel_ready;
  assign at_end = (cur == p1_q);

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (line_ready) state_d = ST_LOAD;
      ST_LOAD:  state_d = line_reject ? ST_IDLE : ST_SETUP;
      ST_SETUP: state_d = ST_DRAW;
      ST_DRAW:  if (accept && at_end) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      p0_q     <= '0;
      p1_q     <= '0;
      reject_q <= 1'b0;
      cur      <= '0;
      err      <= '0;
      dx       <= '0;
      dy       <= '0;
      sx_neg   <= 1'b0;
      sy_neg   <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        ST_LOAD: begin
          p0_q     <= line_p0;
          p1_q     <= line_p1;
          reject_q <= line_reject;
        end
        ST_SETUP: begin
          dx     <= abs_x;
          dy     <= -abs_y;
          err    <= abs_x - abs_y;
          sx_neg <= ~(p0_q.x < p1_q.x);
          sy_neg <= ~(p0_q.y < p1_q.y);
          cur    <= p0_q;
        end
        ST_DRAW: begin
          if (accept && !at_end) begin
            cur <= next_cur;
            err <= next_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
